// File: rtl/h_sync_timing_detector.sv
// Horizontal sync receiver: measures line period and high width, tracks lock.
// Optional +/-TOLERANCE matching when H_SYNC_DETECT_TOLERANCE_EN is defined.
module h_sync_timing_detector #(
  parameter int ZERO            = 0,
  parameter int THRESHOLD_HSYNC = 1072,
  parameter int WHOLE_FRAME     = 1328,
  parameter int COUNTER_SIZE    = 11,
  parameter int LOCK_LINES      = 4,
  parameter int TOLERANCE       = 2
) (
  input  logic                    control_clock,
  input  logic                    control_reset_n,
  input  logic                    h_sync_in,
  output logic [COUNTER_SIZE-1:0] line_period,
  output logic [COUNTER_SIZE-1:0] high_width,
  output logic                    measure_valid,
  output logic                    locked,
  output logic                    timing_error
);

  localparam int CS = COUNTER_SIZE;

  localparam logic [CS-1:0] START  = CS'(ZERO + 1);
  localparam logic [CS-1:0] ONE    = CS'(1);
  localparam logic [CS-1:0] MAX    = '1;
  localparam logic [CS-1:0] FRAME  = CS'(WHOLE_FRAME);
  localparam logic [CS-1:0] THRESH = CS'(THRESHOLD_HSYNC);
  localparam logic [3:0]    LOCK_N = 4'(LOCK_LINES);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  state_t state_q, state_d;

  logic s1, s2, s3;
  logic rise, fall;

  logic [CS-1:0] cnt_q, cnt_d;
  logic [CS-1:0] width_q, width_d;
  logic [CS-1:0] lp_d, hw_d;
  logic [3:0]    match_q, match_d;
  logic          mv_d, lock_d, err_d;
  logic          line_ok;
  logic          timeout;

  // Sync flops reset high so a line already high at reset release
  // does not look like a fresh rise.
  always_ff @(posedge control_clock or negedge control_reset_n) begin
    if (!control_reset_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= h_sync_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

`ifdef H_SYNC_DETECT_TOLERANCE_EN
  localparam logic signed [CS:0] TOL_P = (CS+1)'(TOLERANCE);
  localparam logic signed [CS:0] TOL_N = -TOL_P;

  logic signed [CS:0] dp, dw;

  always_comb begin
    dp = $signed({1'b0, cnt_q}) - $signed({1'b0, FRAME});
    dw = $signed({1'b0, width_q}) - $signed({1'b0, THRESH});
    line_ok = (dp >= TOL_N) && (dp <= TOL_P) &&
              (dw >= TOL_N) && (dw <= TOL_P);
  end
`else
  assign line_ok = (cnt_q == FRAME) && (width_q == THRESH);
`endif

  assign timeout = (state_q != IDLE) && !rise && (cnt_q == MAX - ONE);

  always_comb begin
    state_d = state_q;
    width_d = width_q;
    match_d = match_q;
    lp_d    = line_period;
    hw_d    = high_width;
    mv_d    = 1'b0;
    err_d   = 1'b0;
    lock_d  = locked;

    if (rise) begin
      cnt_d = START;
    end else if (cnt_q == MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + ONE;
    end

    unique case (state_q)
      IDLE: begin
        if (rise) state_d = HIGH;
      end
      HIGH: begin
        if (rise) begin
          err_d   = 1'b1;
          match_d = '0;
          lock_d  = 1'b0;
          state_d = IDLE;
        end else if (fall) begin
          width_d = cnt_q;
          state_d = LOW;
        end
      end
      LOW: begin
        if (rise) begin
          lp_d    = cnt_q;
          hw_d    = width_q;
          mv_d    = 1'b1;
          state_d = HIGH;
          if (line_ok) begin
            if (match_q != LOCK_N) match_d = match_q + 4'd1;
            lock_d = (match_d == LOCK_N);
          end else begin
            match_d = '0;
            lock_d  = 1'b0;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A count running into saturation means the line never completed.
    if (timeout) begin
      err_d   = 1'b1;
      match_d = '0;
      lock_d  = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge control_clock or negedge control_reset_n) begin
    if (!control_reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      width_q       <= '0;
      match_q       <= '0;
      line_period   <= '0;
      high_width    <= '0;
      measure_valid <= 1'b0;
      locked        <= 1'b0;
      timing_error  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      width_q       <= width_d;
      match_q       <= match_d;
      line_period   <= lp_d;
      high_width    <= hw_d;
      measure_valid <= mv_d;
      locked        <= lock_d;
      timing_error  <= err_d;
    end
  end

endmodule

// File: tb/tb_h_sync_timing_detector.sv
// Directed bench for h_sync_timing_detector: nominal lock, deviations,
// glitch, reset mid-line and stuck-high timeout.
module tb_h_sync_timing_detector;

  logic        clk;
  logic        rst_n;
  logic        h;
  logic [10:0] line_period;
  logic [10:0] high_width;
  logic        measure_valid;
  logic        locked;
  logic        timing_error;

  int errors = 0;
  int checks = 0;
  int err_n  = 0;
  int first  = 0;

  logic [10:0] lp_q[$];
  logic [10:0] hw_q[$];
  logic        lk_q[$];
  logic        er_q[$];

  h_sync_timing_detector dut (
    .control_clock  (clk),
    .control_reset_n(rst_n),
    .h_sync_in      (h),
    .line_period    (line_period),
    .high_width     (high_width),
    .measure_valid  (measure_valid),
    .locked         (locked),
    .timing_error   (timing_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (measure_valid) begin
      lp_q.push_back(line_period);
      hw_q.push_back(high_width);
      lk_q.push_back(locked);
      er_q.push_back(timing_error);
    end
    if (timing_error) err_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic line(input int hi, input int lo);
    h = 1'b1;
    repeat (hi) @(negedge clk);
    h = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic clear_logs();
    lp_q.delete();
    hw_q.delete();
    lk_q.delete();
    er_q.delete();
    err_n = 0;
  endtask

  initial begin
    h     = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_lp", line_period, 0);
    chk("rst_hw", high_width, 0);
    chk("rst_mv", measure_valid, 0);
    chk("rst_lock", locked, 0);
    chk("rst_err", timing_error, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // nominal lines
    repeat (6) line(1072, 256);
    chk("nom_count", lp_q.size(), 5);
    chk("nom_lp0", lp_q[0], 1328);
    chk("nom_hw0", hw_q[0], 1072);
    chk("nom_lock2", lk_q[2], 0);
    chk("nom_lock3", lk_q[3], 1);
    chk("nom_lock4", lk_q[4], 1);
    chk("nom_err", err_n, 0);

    // period deviation, then relock
    clear_logs();
    line(1072, 258);
    repeat (5) line(1072, 256);
    chk("pdev_count", lp_q.size(), 6);
    chk("pdev_lp", lp_q[1], 1330);
    chk("pdev_hw", hw_q[1], 1072);
`ifdef H_SYNC_DETECT_TOLERANCE_EN
    chk("pdev_lock", lk_q[1], 1);
    chk("pdev_err", er_q[1], 0);
    chk("pdev_lock_n3", lk_q[4], 1);
    chk("pdev_errs", err_n, 0);
`else
    chk("pdev_lock", lk_q[1], 0);
    chk("pdev_err", er_q[1], 1);
    chk("pdev_lock_n3", lk_q[4], 0);
    chk("pdev_errs", err_n, 1);
`endif
    chk("pdev_relock", lk_q[5], 1);

    // width deviation
    clear_logs();
    line(1060, 268);
    line(1072, 256);
    chk("wdev_prelock", lk_q[0], 1);
    chk("wdev_lp", lp_q[1], 1328);
    chk("wdev_hw", hw_q[1], 1060);
    chk("wdev_lock", lk_q[1], 0);
    chk("wdev_err", er_q[1], 1);

    // relock, then 1-cycle low glitch inside the high phase
    repeat (3) line(1072, 256);
    clear_logs();
    h = 1'b1;
    repeat (500) @(negedge clk);
    h = 1'b0;
    @(negedge clk);
    line(571, 256);
    line(1072, 256);
    chk("gl_prelock", lk_q[0], 1);
    chk("gl_hw", hw_q[1], 500);
    chk("gl_lp", lp_q[1], 501);
    chk("gl_err", er_q[1], 1);
    chk("gl_lock", lk_q[1], 0);
    chk("gl_rest_hw", hw_q[2], 571);
    chk("gl_rest_lp", lp_q[2], 827);

    // relock, then reset in the middle of a high phase
    repeat (3) line(1072, 256);
    h = 1'b1;
    repeat (300) @(negedge clk);
    chk("mid_lock", locked, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_lp", line_period, 0);
    chk("mid_rst_hw", high_width, 0);
    chk("mid_rst_lock", locked, 0);
    chk("mid_rst_mv", measure_valid, 0);
    chk("mid_rst_err", timing_error, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (769) @(negedge clk);
    h = 1'b0;
    repeat (256) @(negedge clk);
    clear_logs();
    line(1072, 256);
    chk("post_rst_none", lp_q.size(), 0);
    line(1072, 256);
    chk("post_rst_one", lp_q.size(), 1);
    chk("post_rst_lp", lp_q[0], 1328);
    chk("post_rst_hw", hw_q[0], 1072);
    chk("post_rst_lock", lk_q[0], 0);

    // stuck high: one timeout 2047 cycles after rise detect
    clear_logs();
    h = 1'b1;
    for (int n = 1; n <= 2100; n++) begin
      @(negedge clk);
      if (timing_error && first == 0) first = n;
    end
    chk("to_time", first, 2049);
    chk("to_once", err_n, 1);
    chk("to_mv", lp_q.size(), 1);
    chk("to_lock", locked, 0);
    h = 1'b0;
    repeat (20) @(negedge clk);
    clear_logs();
    line(1072, 256);
    chk("to_idle", lp_q.size(), 0);
    line(1072, 256);
    chk("to_resume", lp_q.size(), 1);
    chk("to_resume_lp", lp_q[0], 1328);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
